// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared constants and types for the shared multiplier block
// Contents: OP_W/PROD_W operand and product widths, ID_MAX_W widest requester tag,
//           mult_op_t operand pair, mult_rsp_t tagged product.
package mult_share_pkg;

    localparam int OP_W     = 32;
    localparam int PROD_W   = 64;
    localparam int ID_MAX_W = 4;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } mult_op_t;

    typedef struct packed {
        logic [PROD_W-1:0]   prod;
        logic [ID_MAX_W-1:0] id;
    } mult_rsp_t;

endpackage

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - LAT-stage 32x32 multiplier with valid/id sideband and advance enable
// Macro: MULT_SHARE_SIGNED_EN selects two's-complement arithmetic (default unsigned).
// Ports: clk, rst_n (sync active-low); adv moves every stage; in_valid/in_op/in_id enter
//        stage 1; out_valid/out_data/out_id come straight from the last stage registers;
//        busy is the OR of all stage valid bits.
module mult_pipe
    import mult_share_pkg::*;
#(
    parameter int LAT  = 2,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              in_valid,
    input  mult_op_t          in_op,
    input  logic [ID_W-1:0]   in_id,
    output logic              out_valid,
    output logic [PROD_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              busy
);

    // Both operands are widened to PROD_W first, so the truncated 64x64 product is exact.
    function automatic logic [PROD_W-1:0] mul(input mult_op_t op);
        logic [PROD_W-1:0] wa;
        logic [PROD_W-1:0] wb;
`ifdef MULT_SHARE_SIGNED_EN
        wa = {{(PROD_W-OP_W){op.a[OP_W-1]}}, op.a};
        wb = {{(PROD_W-OP_W){op.b[OP_W-1]}}, op.b};
`else
        wa = {{(PROD_W-OP_W){1'b0}}, op.a};
        wb = {{(PROD_W-OP_W){1'b0}}, op.b};
`endif
        return wa * wb;
    endfunction

    generate
        if (LAT == 1) begin : g_lat1
            // Single stage: the product itself is the only register.
            logic              v_q;
            logic [ID_W-1:0]   id_q;
            logic [PROD_W-1:0] prod_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q    <= 1'b0;
                    id_q   <= '0;
                    prod_q <= '0;
                end else if (adv) begin
                    v_q    <= in_valid;
                    id_q   <= in_id;
                    prod_q <= mul(in_op);
                end
            end

            assign out_valid = v_q;
            assign out_id    = id_q;
            assign out_data  = prod_q;
            assign busy      = v_q;
        end else begin : g_latn
            // Stage 1 holds operands; stage 2 multiplies; later stages only delay.
            logic [LAT-1:0]    v_q;
            logic [ID_W-1:0]   id_q   [LAT];
            mult_op_t          op_q;
            logic [PROD_W-1:0] prod_q [LAT-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q  <= '0;
                    op_q <= '0;
                    for (int i = 0; i < LAT; i++) id_q[i] <= '0;
                    for (int i = 0; i < LAT - 1; i++) prod_q[i] <= '0;
                end else if (adv) begin
                    v_q[0]    <= in_valid;
                    id_q[0]   <= in_id;
                    op_q      <= in_op;
                    prod_q[0] <= mul(op_q);
                    for (int i = 1; i < LAT; i++) begin
                        v_q[i]  <= v_q[i-1];
                        id_q[i] <= id_q[i-1];
                    end
                    for (int i = 1; i < LAT - 1; i++) prod_q[i] <= prod_q[i-1];
                end
            end

            assign out_valid = v_q[LAT-1];
            assign out_id    = id_q[LAT-1];
            assign out_data  = prod_q[LAT-2];
            assign busy      = |v_q;
        end
    endgenerate

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one multiplier among N_REQ requesters
// Macro: MULT_SHARE_SIGNED_EN (passed through to mult_pipe) selects signed products.
// Ports: clk, rst_n (sync active-low); req_valid/req_ready/req_a/req_b per-requester
//        request handshake (32-bit lanes packed by index); rsp_valid/rsp_ready/rsp_data/
//        rsp_id tagged product output; busy when any pipeline stage is occupied.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PROD_W-1:0]     rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            adv;
    logic            accept;
    mult_op_t        op;

    // The whole pipeline freezes only when a product is presented and refused.
    assign adv    = !(rsp_valid && !rsp_ready);
    assign accept = found && adv;

    // Scan from the farthest offset down so the lowest offset from ptr wins last.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        op.a = req_a[OP_W*winner +: OP_W];
        op.b = req_b[OP_W*winner +: OP_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    mult_pipe #(
        .LAT  (LAT),
        .ID_W (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .in_valid  (accept),
        .in_op     (op),
        .in_id     (winner),
        .out_valid (rsp_valid),
        .out_data  (rsp_data),
        .out_id    (rsp_id),
        .busy      (busy)
    );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - table-driven bench for mult_share_arbiter (N_REQ=4, LAT=2)
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_rv;
        logic [1:0] exp_id;
        logic       exp_busy;
        logic       chk;
    } vec_t;

    vec_t        tbl [39];
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic [63:0] prod [4];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rd,
                                input logic [3:0] er, input logic rv, input logic [1:0] id,
                                input logic bz, input logic c);
        vec_t t;
        t.rst_n = r; t.valid = v; t.rdy = rd; t.exp_ready = er;
        t.exp_rv = rv; t.exp_id = id; t.exp_busy = bz; t.chk = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic single(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_prod);
        mult_rsp_t exp;
        logic      got;
        exp.prod = exp_prod;
        exp.id   = 4'(idx);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_valid      = 4'b0;
        req_valid[idx] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            #1;
            got = req_ready[idx];
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0;
        chk($sformatf("single%0d accept", idx), {63'b0, got}, 64'd1);
        #1;
        chk($sformatf("single%0d early valid", idx), {63'b0, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk($sformatf("single%0d rsp_valid", idx), {63'b0, rsp_valid}, 64'd1);
        chk($sformatf("single%0d rsp_data", idx), rsp_data, exp.prod);
        chk($sformatf("single%0d rsp_id", idx), {62'b0, rsp_id}, {60'b0, exp.id});
        @(posedge clk);
        #1;
        chk($sformatf("single%0d drained", idx), {63'b0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_a[0] = 32'h0000_0003; op_b[0] = 32'h0000_0005; prod[0] = 64'h0000_0000_0000_000F;
        op_a[1] = 32'hFFFF_FFFF; op_b[1] = 32'hFFFF_FFFF;
`ifdef MULT_SHARE_SIGNED_EN
        prod[1] = 64'h0000_0000_0000_0001;
`else
        prod[1] = 64'hFFFF_FFFE_0000_0001;
`endif
        op_a[2] = 32'h0000_0007; op_b[2] = 32'h0000_0009; prod[2] = 64'h0000_0000_0000_003F;
        op_a[3] = 32'h0001_0000; op_b[3] = 32'h0001_0000; prod[3] = 64'h0000_0001_0000_0000;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = op_a[i];
            req_b[32*i +: 32] = op_b[i];
        end

        //           rst  valid rdy ready rv id busy chk
        tbl[0]  = mk(1'b0, 4'h0, 1'b1, 4'h0, 0, 0, 0, 0);
        // all four requesters from reset: grants 0,1,2,3,0,1,2,3
        tbl[1]  = mk(1'b1, 4'hF, 1'b1, 4'h1, 0, 0, 0, 1);
        tbl[2]  = mk(1'b1, 4'hF, 1'b1, 4'h2, 0, 0, 1, 1);
        tbl[3]  = mk(1'b1, 4'hF, 1'b1, 4'h4, 1, 0, 1, 1);
        tbl[4]  = mk(1'b1, 4'hF, 1'b1, 4'h8, 1, 1, 1, 1);
        tbl[5]  = mk(1'b1, 4'hF, 1'b1, 4'h1, 1, 2, 1, 1);
        tbl[6]  = mk(1'b1, 4'hF, 1'b1, 4'h2, 1, 3, 1, 1);
        tbl[7]  = mk(1'b1, 4'hF, 1'b1, 4'h4, 1, 0, 1, 1);
        tbl[8]  = mk(1'b1, 4'hF, 1'b1, 4'h8, 1, 1, 1, 1);
        tbl[9]  = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 2, 1, 1);
        tbl[10] = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 3, 1, 1);
        tbl[11] = mk(1'b1, 4'h0, 1'b1, 4'h0, 0, 0, 0, 1);
        // fill pipeline with rsp_ready low, stall five cycles, release
        tbl[12] = mk(1'b1, 4'hF, 1'b0, 4'h1, 0, 0, 0, 1);
        tbl[13] = mk(1'b1, 4'hF, 1'b0, 4'h2, 0, 0, 1, 1);
        for (int i = 14; i <= 18; i++) tbl[i] = mk(1'b1, 4'hF, 1'b0, 4'h0, 1, 0, 1, 1);
        tbl[19] = mk(1'b1, 4'hF, 1'b1, 4'h4, 1, 0, 1, 1);
        tbl[20] = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 1, 1, 1);
        tbl[21] = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 2, 1, 1);
        tbl[22] = mk(1'b1, 4'h0, 1'b1, 4'h0, 0, 0, 0, 1);
        // sparse: requester 2 alone, then requester 1 (ptr is 3 here)
        tbl[23] = mk(1'b1, 4'h4, 1'b1, 4'h4, 0, 0, 0, 1);
        tbl[24] = mk(1'b1, 4'h2, 1'b1, 4'h2, 0, 0, 1, 1);
        tbl[25] = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 2, 1, 1);
        tbl[26] = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 1, 1, 1);
        tbl[27] = mk(1'b1, 4'h0, 1'b1, 4'h0, 0, 0, 0, 1);
        // two in flight, then reset for one edge
        tbl[28] = mk(1'b1, 4'hF, 1'b1, 4'h4, 0, 0, 0, 1);
        tbl[29] = mk(1'b1, 4'hF, 1'b1, 4'h8, 0, 0, 1, 1);
        tbl[30] = mk(1'b0, 4'h0, 1'b1, 4'h0, 1, 2, 1, 1);
        for (int i = 31; i <= 34; i++) tbl[i] = mk(1'b1, 4'h0, 1'b1, 4'h0, 0, 0, 0, 1);
        // pointer restarted at 0
        tbl[35] = mk(1'b1, 4'hF, 1'b1, 4'h1, 0, 0, 0, 1);
        tbl[36] = mk(1'b1, 4'h0, 1'b1, 4'h0, 0, 0, 1, 1);
        tbl[37] = mk(1'b1, 4'h0, 1'b1, 4'h0, 1, 0, 1, 1);
        tbl[38] = mk(1'b1, 4'h0, 1'b1, 4'h0, 0, 0, 0, 1);

        for (int i = 0; i < 39; i++) begin
            rst_n     = tbl[i].rst_n;
            req_valid = tbl[i].valid;
            rsp_ready = tbl[i].rdy;
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("v%0d req_ready", i), {60'b0, req_ready}, {60'b0, tbl[i].exp_ready});
                chk($sformatf("v%0d rsp_valid", i), {63'b0, rsp_valid}, {63'b0, tbl[i].exp_rv});
                chk($sformatf("v%0d busy", i), {63'b0, busy}, {63'b0, tbl[i].exp_busy});
                if (tbl[i].exp_rv) begin
                    chk($sformatf("v%0d rsp_id", i), {62'b0, rsp_id}, {62'b0, tbl[i].exp_id});
                    chk($sformatf("v%0d rsp_data", i), rsp_data, prod[tbl[i].exp_id]);
                end
                if (i == 1 || i == 31) begin
                    chk($sformatf("v%0d reset rsp_data", i), rsp_data, 64'd0);
                    chk($sformatf("v%0d reset rsp_id", i), {62'b0, rsp_id}, 64'd0);
                end
            end
            @(posedge clk);
            #1;
        end

        rsp_ready = 1'b1;
        single(0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);
`ifdef MULT_SHARE_SIGNED_EN
        single(3, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
        single(2, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        single(3, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
        single(2, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA);
`endif
        single(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, prod[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and pipeline sequencer that shares one 32x32=64 multiplier between N_REQ independent requesters. Each requester presents operand pairs over a valid/ready handshake. The block grants at most one request per cycle, carries the requester ID through a LAT-stage multiply pipeline, and returns tagged 64-bit products on a single shared response channel with backpressure. It sits between the compute clients and the multiplier datapath, so no client ever drives the multiplier directly.

## Interface
- N_REQ, default 4: number of requesters, 2..16.
- LAT, default 2: cycles from request acceptance to `rsp_valid`, 1..4.
- ID_W, default $clog2(N_REQ): width of the response tag.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  request present, one bit per requester.
- req_ready  out  N_REQ  request accepted this cycle; at most one bit is high.
- req_a  in  N_REQ*32  operand A; requester i uses bits [32*i+31:32*i].
- req_b  in  N_REQ*32  operand B; same packing as `req_a`.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_data  out  64  product A*B.
- rsp_id  out  ID_W  index of the requester that issued the product.
- busy  out  1  at least one pipeline stage holds a valid entry.

## Operation
- Handshakes:
  - A request transfers when `req_valid[i] && req_ready[i]`.
  - A response transfers when `rsp_valid && rsp_ready`.
  - After asserting `req_valid[i]`, a requester holds it and its operands stable until the transfer.
- Advance signal: `adv = !(rsp_valid && !rsp_ready)`. The whole pipeline moves one stage on `adv` and freezes otherwise. There is no partial bubble collapse.
- Arbitration:
  - Round-robin with a priority pointer `ptr`, reset to 0.
  - The winner is the first index at or after `ptr`, wrapping modulo N_REQ, with `req_valid` high.
  - `req_ready[winner] = adv`. All other `req_ready` bits are 0.
  - On each acceptance, `ptr` becomes winner+1, wrapping to 0 after N_REQ-1.
  - With no acceptance, `ptr` holds.
- Arbitration is combinational from `req_valid` and `ptr`. `req_ready` never depends on `req_a` or `req_b`.
- Pipeline:
  - Stage 1 registers a, b, id and a valid bit.
  - Intermediate stages register the product, or partial products, plus id and valid.
  - The final stage drives `rsp_*` directly from registers.
  - Every stage's valid bit is cleared when no request was accepted into it on an advance, so empty slots are bubbles.
- Arithmetic:
  - The product is the full 64-bit result with no truncation or overflow.
  - Unsigned by default; see Configuration.
- `busy` is the OR of all stage valid bits.

## Timing
- Reset values (while `rst_n` is low at a clock edge):
  - All stage valid bits = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `ptr` = 0, `busy` = 0.
- `req_ready` = 0 in the cycle following reset assertion, because `adv` is still true but no request is pending.
- Reset mid-operation discards every in-flight product. No response is emitted for them.
- Latency:
  - A request accepted at edge k produces `rsp_valid` = 1 after edge k+LAT, assuming no stall.
  - Throughput is 1 product per cycle.
- Stall:
  - While `rsp_valid && !rsp_ready`, all `req_ready` bits are 0 and all stages hold.
  - `rsp_data` and `rsp_id` stay stable.
- Release:
  - In the cycle `rsp_ready` rises, the held product transfers.
  - A new request may be accepted in that same cycle.
- Simultaneous requests: all N_REQ asserted continuously gives grants ptr, ptr+1, …, wrapping. Each requester is served exactly once per N_REQ accepted grants.
- Pipeline full with `rsp_ready` low: no further acceptance occurs, and nothing is dropped or overwritten.

## Configuration
- MULT_SHARE_SIGNED_EN:
  - Defined: operands are two's-complement and the product is the signed 64-bit result.
  - Undefined: operands and product are unsigned.
- The macro affects only the multiplier arithmetic. Handshake and latency behaviour are identical either way.

## Structure
- Shared package `mult_share_pkg`:
  - Constants `OP_W=32`, `PROD_W=64`.
  - Typedef `mult_op_t` for the operand pair.
  - Typedef `mult_rsp_t` for product plus id.
- One sub-module, `mult_pipe`:
  - LAT-stage multiplier with valid/id sideband and an `adv` enable.
  - It contains the signed/unsigned selection.
  - `mult_share_arbiter` holds only arbitration, `ptr` and handshake logic.

## Test plan
- Single requester, LAT=2: requester 0 sends a=0x0000_0003, b=0x0000_0005 at edge k. The response is `rsp_valid` at edge k+2 with `rsp_data`=0x0000_0000_0000_000F and `rsp_id`=0.
- Maximum operands, unsigned build: a=b=0xFFFF_FFFF gives `rsp_data`=0xFFFF_FFFE_0000_0001.
  - With MULT_SHARE_SIGNED_EN, a=0xFFFF_FFFF and b=0x0000_0002 give 0xFFFF_FFFF_FFFF_FFFE.
- Round-robin: all 4 requesters valid for 8 cycles from reset. The grant order is 0,1,2,3,0,1,2,3 and `rsp_id` follows the same order LAT cycles later.
- Backpressure: `rsp_ready`=0 for 5 cycles with the pipeline full.
  - `req_ready` stays 0 and `rsp_data`/`rsp_id` stay stable.
  - After release, all products arrive in order with none lost or duplicated.
- Reset mid-flight: assert `rst_n`=0 for one edge while 2 products are in flight.
  - Afterwards `rsp_valid`=0, `busy`=0 and `ptr`=0.
  - No stale response appears in the following LAT+2 cycles.
- Sparse traffic: requester 2 alone, then requester 1. The grants are 2 then 1; the pointer skips idle requesters.
